seg_time_disp: RTL

- Consumer end of the time-of-day counter: takes binary h_dec/m_dec/s_dec and drives a 6-digit multiplexed common-anode 7-segment display (HH MM SS).
- Time values are latched once per scan frame so a frame never shows a mix of old and new time.
- Each value is converted to two BCD digits, and one digit is driven at a time at a fixed scan rate.

---
 rtl/seg_disp_pkg.sv | 20 ++
 rtl/seg_time_disp_if.sv | 16 +
 rtl/bin2bcd_99.sv | 17 +
 rtl/seg_time_disp.sv | 68 ++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared constants for the six-digit seven-segment time display.
// Holds digit count, digit-position indices, active-low segment codes
// (seg[7]=dp, seg[6:0]=g..a) and a digit-to-segment helper.
package seg_disp_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic [2:0] IDX_S_U = 3'd0;
  localparam logic [2:0] IDX_S_T = 3'd1;
  localparam logic [2:0] IDX_M_U = 3'd2;
  localparam logic [2:0] IDX_M_T = 3'd3;
  localparam logic [2:0] IDX_H_U = 3'd4;
  localparam logic [2:0] IDX_H_T = 3'd5;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEG_CODE [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    return (d > 4'd9) ? SEG_OFF : SEG_CODE[d];
  endfunction
endpackage

// File: rtl/seg_time_disp_if.sv
// seg_time_disp_if: time-in / display-out bundle of the seven-segment display.
// s_dec/m_dec/h_dec : binary seconds/minutes/hours from the time source
// sel               : active-low digit enables, sel[0] = seconds units
// seg               : active-low segments, seg[7]=dp, seg[6:0]=g..a
// master drives the time values, slave is the display block.
interface seg_time_disp_if
  import seg_disp_pkg::*;
;
  logic [7:0] s_dec;
  logic [7:0] m_dec;
  logic [7:0] h_dec;
  logic [NUM_DIGITS-1:0] sel;
  logic [7:0] seg;
  modport master (output s_dec, m_dec, h_dec, input sel, seg);
  modport slave (input s_dec, m_dec, h_dec, output sel, seg);
endinterface

// File: rtl/bin2bcd_99.sv
// bin2bcd_99: combinational split of a binary value 0..99 into two BCD digits.
// in_i    : 8-bit binary value
// tens_o  : in_i / 10 (meaningful only when ovf_o is low)
// units_o : in_i % 10 (meaningful only when ovf_o is low)
// ovf_o   : in_i > 99, value cannot be shown in two digits
module bin2bcd_99 (
  input  logic [7:0] in_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       ovf_o
);
  always_comb begin
    ovf_o = in_i > 8'd99;
    tens_o = 4'(in_i / 8'd10);
    units_o = 4'(in_i % 8'd10);
  end
endmodule

// File: rtl/seg_time_disp.sv
// seg_time_disp: multiplexed six-digit common-anode display of HH MM SS.
// clk   : system clock
// rst_n : synchronous active-low reset, display dark while low
// bus   : seg_time_disp_if.slave (time in, sel/seg out)
// Optional macro SEG_DP_BLINK_EN: lights dp on minutes/hours units digits
// while the latched seconds value is even (1 Hz colon substitute).
module seg_time_disp
  import seg_disp_pkg::*;
#(
  parameter logic [15:0] CNT_SCAN = 16'd49_999
) (
  input logic clk,
  input logic rst_n,
  seg_time_disp_if.slave bus
);
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] s_q, s_d, m_q, m_d, h_q, h_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0] seg_q, seg_d;
  logic [3:0] s_t, s_u, m_t, m_u, h_t, h_u, dig;
  logic s_ovf, m_ovf, h_ovf, ovf, step, wrap;
  bin2bcd_99 u_s (.in_i(s_q), .tens_o(s_t), .units_o(s_u), .ovf_o(s_ovf));
  bin2bcd_99 u_m (.in_i(m_q), .tens_o(m_t), .units_o(m_u), .ovf_o(m_ovf));
  bin2bcd_99 u_h (.in_i(h_q), .tens_o(h_t), .units_o(h_u), .ovf_o(h_ovf));
  always_comb begin
    step = cnt_q == CNT_SCAN;
    wrap = step && idx_q == IDX_H_T;
    cnt_d = step ? '0 : cnt_q + 16'd1;
    idx_d = wrap ? IDX_S_U : idx_q + 3'(step);
    // Time is captured only at the frame boundary so one frame never mixes old and new values.
    s_d = wrap ? bus.s_dec : s_q;
    m_d = wrap ? bus.m_dec : m_q;
    h_d = wrap ? bus.h_dec : h_q;
    dig = idx_q == IDX_S_U ? s_u :
          idx_q == IDX_S_T ? s_t :
          idx_q == IDX_M_U ? m_u :
          idx_q == IDX_M_T ? m_t :
          idx_q == IDX_H_U ? h_u : h_t;
    ovf = idx_q < IDX_M_U ? s_ovf : idx_q < IDX_H_U ? m_ovf : h_ovf;
    sel_d = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = ovf ? SEG_DASH : seg_of(dig);
`ifdef SEG_DP_BLINK_EN
    if (!ovf && !s_q[0] && (idx_q == IDX_M_U || idx_q == IDX_H_U)) seg_d[7] = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= IDX_S_U;
      s_q <= '0;
      m_q <= '0;
      h_q <= '0;
      sel_q <= '1;
      seg_q <= SEG_OFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      s_q <= s_d;
      m_q <= m_d;
      h_q <= h_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end
  assign bus.sel = sel_q;
  assign bus.seg = seg_q;
endmodule
